comparator_serial_ctrl: RTL



---
 rtl/comparator_serial_ctrl_if.sv | 26 ++
 rtl/comparator_serial_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/comparator_serial_ctrl_if.sv
// Handshake/operand/result bundle for comparator_serial_ctrl.
//   master : drives start, a, b; observes busy, done, L, E, G
//   slave  : the controller side (inverse directions)
// WIDTH must match the WIDTH of the attached controller.
interface comparator_serial_ctrl_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             L;
   logic             E;
   logic             G;

   modport master (
      output start, a, b,
      input  busy, done, L, E, G
   );

   modport slave (
      input  start, a, b,
      output busy, done, L, E, G
   );
endinterface

// File: rtl/comparator_serial_ctrl.sv
// Bit-serial unsigned magnitude comparator controller. Operands captured on
// an accepted start are scanned MSB-first through a single 1-bit compare
// cell, one bit per clock; a registered L/E/G verdict is presented with a
// one-cycle done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - comparator_serial_ctrl_if.slave: start, a, b in; busy, done,
//          L, E, G out (all outputs registered)
// Configuration macro: COMPARATOR_SERIAL_EARLY_EXIT_EN
//   defined   - finish on the first mismatching bit
//   undefined - always scan all WIDTH bits (fixed latency WIDTH+1)
module comparator_serial_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   comparator_serial_ctrl_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;

   // 1-bit comparator cell on the current MSBs
   logic cell_l;
   logic cell_g;

   always_comb begin
      cell_l = ~sa[WIDTH-1] &  sb[WIDTH-1];
      cell_g =  sa[WIDTH-1] & ~sb[WIDTH-1];
   end

`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
   // The first mismatch is remembered; later bits cannot override it.
   logic seen_lt;
   logic seen_gt;
   logic lt_fin;
   logic gt_fin;

   always_comb begin
      lt_fin = seen_lt | (~seen_gt & cell_l);
      gt_fin = seen_gt | (~seen_lt & cell_g);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.L    <= 1'b0;
         bus.E    <= 1'b0;
         bus.G    <= 1'b0;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
         seen_lt  <= 1'b0;
         seen_gt  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  sa       <= bus.a;
                  sb       <= bus.b;
                  cnt      <= CW'(WIDTH - 1);
                  bus.L    <= 1'b0;
                  bus.E    <= 1'b0;
                  bus.G    <= 1'b0;
                  bus.busy <= 1'b1;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
                  seen_lt  <= 1'b0;
                  seen_gt  <= 1'b0;
`endif
                  state    <= CMP;
               end else begin
                  state    <= IDLE;
               end
            end

            CMP: begin
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
               if (cell_l | cell_g) begin
                  bus.L    <= cell_l;
                  bus.G    <= cell_g;
                  bus.E    <= 1'b0;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else if (cnt == '0) begin
                  bus.E    <= 1'b1;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  sa  <= sa << 1;
                  sb  <= sb << 1;
                  cnt <= cnt - CW'(1);
               end
`else
               seen_lt <= lt_fin;
               seen_gt <= gt_fin;
               if (cnt == '0) begin
                  bus.L    <= lt_fin;
                  bus.G    <= gt_fin;
                  bus.E    <= ~(lt_fin | gt_fin);
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  sa  <= sa << 1;
                  sb  <= sb << 1;
                  cnt <= cnt - CW'(1);
               end
`endif
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end
endmodule
